// File: rtl/minesweeper_reveal_engine_pkg.sv
// minesweeper_pkg: cell bit layout, neighbour order/offset table and FSM states for the reveal engine
package minesweeper_pkg;
  localparam int BOMB_B = 6;
  localparam int COV_B = 5;
  localparam int FLAG_B = 4;
  localparam int ADJ_MSB = 2;
  localparam logic [15:0] NB_DR = {2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
  localparam logic [15:0] NB_DC = {2'd2, 2'd1, 2'd0, 2'd2, 2'd0, 2'd2, 2'd1, 2'd0};
  typedef enum logic [2:0] {IDLE, RD_START, EV_START, POP, NB_ISSUE, NB_WAIT, NB_EVAL, DONE} state_t;
  function automatic logic [1:0] nb_dr(input logic [2:0] n);
    return NB_DR[{n, 1'b0} +: 2];
  endfunction
  function automatic logic [1:0] nb_dc(input logic [2:0] n);
    return NB_DC[{n, 1'b0} +: 2];
  endfunction
  function automatic logic [6:0] uncover(input logic [6:0] c);
    logic [6:0] r;
    r = c;
    r[COV_B] = 1'b0;
    return r;
  endfunction
endpackage

// File: rtl/minesweeper_reveal_engine_if.sv
// minesweeper_reveal_engine_if: request/status and board-RAM bundle of the reveal engine
interface minesweeper_reveal_engine_if #(
  parameter int BOARD_W = 16,
  parameter int BOARD_H = 16
);
  localparam int POS_W = $clog2(BOARD_W * BOARD_H);
  logic start;
  logic [POS_W-1:0] start_pos;
  logic [POS_W-1:0] mem_addr;
  logic [6:0] mem_rdata;
  logic [6:0] mem_wdata;
  logic mem_we;
  logic busy;
  logic done;
  logic hit_bomb;
  logic overflow;
  logic [POS_W:0] revealed_count;
  modport master (
    output start, start_pos, mem_rdata,
    input mem_addr, mem_wdata, mem_we, busy, done, hit_bomb, overflow, revealed_count
  );
  modport slave (
    input start, start_pos, mem_rdata,
    output mem_addr, mem_wdata, mem_we, busy, done, hit_bomb, overflow, revealed_count
  );
endinterface

// File: rtl/minesweeper_reveal_engine_fifo.sv
// reveal_fifo: circular first-word-fall-through queue of cell indices
module reveal_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic reset,
  input logic push,
  input logic pop,
  input logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] buf_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  assign empty = wr_q == rd_q;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout = buf_q[rd_q[AW-1:0]];
  always_comb begin
    wr_d = (push && !full) ? wr_q + 1'b1 : wr_q;
    rd_d = (pop && !empty) ? rd_q + 1'b1 : rd_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
    if (push && !full) buf_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/minesweeper_reveal_engine.sv
// minesweeper_reveal_engine: uncovers a start cell and flood-fills zero-count regions through board RAM
module minesweeper_reveal_engine
  import minesweeper_pkg::*;
#(
  parameter int BOARD_W = 16,
  parameter int BOARD_H = 16,
  parameter int QUEUE_DEPTH = 64
) (
  input logic clk,
  input logic reset,
  minesweeper_reveal_engine_if.slave bus
);
  localparam int POS_W = $clog2(BOARD_W * BOARD_H);
  state_t state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d, ctr_q, ctr_d, nb_addr, addr, push_din, fifo_dout;
  logic [2:0] n_q, n_d;
  logic hit_q, hit_d, ovf_q, ovf_d;
  logic [POS_W:0] cnt_q, cnt_d;
  logic push, pop, full, empty, in_b, we;
  logic bomb, covered, flagged, adj_zero;
  logic [1:0] dr, dc;
  int row, col;
  assign bomb = bus.mem_rdata[BOMB_B];
  assign covered = bus.mem_rdata[COV_B];
  assign flagged = bus.mem_rdata[FLAG_B];
  assign adj_zero = bus.mem_rdata[ADJ_MSB:0] == '0;
  reveal_fifo #(.DEPTH(QUEUE_DEPTH), .WIDTH(POS_W)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(push_din),
    .dout(fifo_dout),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    dr = nb_dr(n_q);
    dc = nb_dc(n_q);
    row = int'(ctr_q) / BOARD_W;
    col = int'(ctr_q) % BOARD_W;
    in_b = !(dr == 2'd0 && row == 0) && !(dr == 2'd2 && row == BOARD_H - 1) &&
           !(dc == 2'd0 && col == 0) && !(dc == 2'd2 && col == BOARD_W - 1);
    nb_addr = POS_W'(int'(ctr_q) + (int'(dr) - 1) * BOARD_W + int'(dc) - 1);
  end
  always_comb begin
    state_d = state_q;
    pos_d = pos_q;
    ctr_d = ctr_q;
    n_d = n_q;
    hit_d = hit_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    addr = pos_q;
    we = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    push_din = pos_q;
    case (state_q)
      IDLE: begin
        addr = bus.start_pos;
        if (bus.start) begin
          state_d = RD_START;
          pos_d = bus.start_pos;
          hit_d = 1'b0;
          ovf_d = 1'b0;
          cnt_d = '0;
        end
      end
      RD_START: state_d = EV_START;
      EV_START: begin
        we = covered && !flagged;
        hit_d = we && bomb;
        push = we && !bomb && adj_zero;
        state_d = push ? POP : DONE;
      end
      POP: begin
        pop = !empty;
        ctr_d = fifo_dout;
        n_d = '0;
        state_d = empty ? DONE : NB_ISSUE;
      end
      NB_ISSUE: begin
        addr = in_b ? nb_addr : pos_q;
        n_d = in_b ? n_q : n_q + 3'd1;
        state_d = in_b ? NB_WAIT : (n_q == 3'd7 ? POP : NB_ISSUE);
      end
      NB_WAIT: begin
        addr = nb_addr;
        state_d = NB_EVAL;
      end
      NB_EVAL: begin
        addr = nb_addr;
        we = covered && !flagged && !bomb;
        push = we && adj_zero;
        push_din = nb_addr;
        n_d = n_q + 3'd1;
        state_d = n_q == 3'd7 ? POP : NB_ISSUE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cnt_d = we ? cnt_q + 1'b1 : cnt_d;
    ovf_d = ovf_d | (push & full);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pos_q <= '0;
      ctr_q <= '0;
      n_q <= '0;
      hit_q <= 1'b0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pos_q <= pos_d;
      ctr_q <= ctr_d;
      n_q <= n_d;
      hit_q <= hit_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end
  assign bus.mem_addr = reset ? '0 : addr;
  assign bus.mem_wdata = reset ? '0 : uncover(bus.mem_rdata);
  assign bus.mem_we = we && !reset;
  assign bus.busy = !reset && state_q != IDLE && state_q != DONE;
  assign bus.done = !reset && state_q == DONE;
  assign bus.hit_bomb = hit_q && !reset;
  assign bus.overflow = ovf_q && !reset;
  assign bus.revealed_count = reset ? '0 : cnt_q;
endmodule

// File: doc/minesweeper_reveal_engine.md
MINESWEEPER_REVEAL_ENGINE -- requirements
Module: minesweeper_reveal_engine

Interface
REQ-001 SHALL take parameter BOARD_W, default 16: board columns.
REQ-002 SHALL take parameter BOARD_H, default 16: board rows.
REQ-003 SHALL take parameter QUEUE_DEPTH, default 64: flood-fill queue entries, power of two.
REQ-004 SHALL derive POS_W = clog2(BOARD_W*BOARD_H); POS_W is not user-settable.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle request to reveal start_pos.
REQ-008 start_pos  in  POS_W  linear cell index: row*BOARD_W+col.
REQ-009 mem_addr  out  POS_W  board RAM address.
REQ-010 mem_rdata  in  7  cell word; valid one cycle after mem_addr.
REQ-011 mem_wdata  out  7  cell word to write.
REQ-012 mem_we  out  1  write strobe.
REQ-013 busy  out  1  high from the cycle after an accepted start until done.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 hit_bomb  out  1  sticky per operation: start cell was a bomb.
REQ-016 overflow  out  1  sticky per operation: an enqueue was dropped.
REQ-017 revealed_count  out  POS_W+1  cells uncovered by the current/last operation.

Function
REQ-018 Cell word SHALL be: bit6 bomb, bit5 covered, bit4 flagged, bits2:0 adjacent-bomb count; bit3 reserved, written back unchanged.
REQ-019 FSM states SHALL be IDLE, RD_START, EV_START, POP, NB_ISSUE, NB_WAIT, NB_EVAL, DONE.
REQ-020 IDLE: on start, latch start_pos, drive mem_addr, clear hit_bomb/overflow/revealed_count, go RD_START; start is ignored in every other state.
REQ-021 RD_START waits one cycle, then EV_START.
REQ-022 EV_START: covered=0 or flagged=1 -> no write, DONE; bomb=1 -> write covered=0, hit_bomb=1, DONE; otherwise write covered=0, revealed_count+1, enqueue start_pos if count==0 and go POP, else DONE.
REQ-023 POP: queue empty -> DONE; else dequeue centre, neighbour index n=0, go NB_ISSUE.
REQ-024 NB_ISSUE: neighbours in order NW,N,NE,W,E,SW,S,SE; out-of-bounds (row/col edge test, never linear wrap) skips in one cycle without a memory access; in-bounds drives mem_addr, goes NB_WAIT.
REQ-025 NB_EVAL: covered=1, flagged=0, bomb=0 -> write covered=0, revealed_count+1, enqueue if count==0; any other cell: no write.
REQ-026 Enqueue while queue full SHALL drop the entry, set overflow, still uncover the cell and continue.
REQ-027 After n=7 SHALL return to POP; otherwise n+1, NB_ISSUE.
REQ-028 DONE asserts done for exactly one cycle, busy=0, returns to IDLE.
REQ-029 Each in-bounds neighbour SHALL cost 3 cycles; mem_we SHALL be high at most one cycle per cell visit.
REQ-030 A cell SHALL never be enqueued twice in one operation (guaranteed by covered check before write).

Reset
REQ-031 Reset SHALL force IDLE, empty queue, and all outputs to 0, including mid-operation; mem_we SHALL be 0 in the reset cycle.
REQ-032 First start after reset release SHALL be accepted normally.

Structure
REQ-033 Package minesweeper_pkg SHALL hold cell bit positions, neighbour order/offset encoding and the FSM state enum.
REQ-034 Queue SHALL be sub-module reveal_fifo (circular buffer, params DEPTH and WIDTH, push/pop/full/empty, sync reset).

Verification (BOARD_W=BOARD_H=4 unless stated)
REQ-035 Flagged cell 5, start_pos=5 -> no mem_we, done, revealed_count=0.
REQ-036 Bomb at 5, start_pos=5 -> one write covered=0, hit_bomb=1, revealed_count=1.
REQ-037 No bombs, QUEUE_DEPTH=16, start_pos=0 -> all 16 cells uncovered, revealed_count=16, overflow=0.
REQ-038 Centre 3 dequeued -> in-bounds reads only addresses 2,6,7; never 4 or 8.
REQ-039 No bombs, QUEUE_DEPTH=2, start_pos=0 -> overflow=1, done pulses, revealed_count<=16.
REQ-040 Reset asserted in NB_WAIT -> next cycle busy=0, mem_we=0; new start on 0 completes normally.
